// File: rtl/vga_window_streamer.sv
// Avalon-ST video frame generator: centred line-buffer window with border columns
// on a background colour. It honours backpressure and stops only on frame boundaries.
`timescale 1ns/1ps
module vga_window_streamer #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned WIN_START   = 80,
   parameter int unsigned WIN_WIDTH   = 480,
   parameter int unsigned COLOR_BITS  = 8,
   parameter int unsigned OUT_BITS    = 10,
   parameter int unsigned ADDR_W      = 9,
   parameter logic [3*COLOR_BITS-1:0] BORDER_RGB = 24'hFFFFFF,
   parameter logic [3*COLOR_BITS-1:0] BG_RGB     = 24'h000000,
   parameter int unsigned ROW_LEAD    = 80,
   parameter int unsigned SCREEN_LEAD = 740
) (
   input  logic                      clock_vga,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [3*COLOR_BITS-1:0]   data,
   output logic [ADDR_W-1:0]         address,
   output logic                      next_row,
   output logic                      next_screen,
   output logic [3*OUT_BITS-1:0]     src_data,
   output logic                      src_valid,
   input  logic                      src_ready,
   output logic                      src_sop,
   output logic                      src_eop
);

   localparam int unsigned X_W   = $clog2(H_ACTIVE);
   localparam int unsigned Y_W   = $clog2(V_ACTIVE);
   localparam int unsigned LIN_W = $clog2(H_ACTIVE * V_ACTIVE);
   localparam int unsigned PAD   = OUT_BITS - COLOR_BITS;

   localparam logic [X_W-1:0]      X_LAST      = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]      Y_LAST      = Y_W'(V_ACTIVE - 1);
   localparam logic [X_W-1:0]      WIN_FIRST   = X_W'(WIN_START);
   localparam logic [X_W-1:0]      WIN_LAST    = X_W'(WIN_START + WIN_WIDTH - 1);
   localparam logic [X_W-1:0]      BORDER_L    = X_W'(WIN_START - 1);
   localparam logic [X_W-1:0]      BORDER_R    = X_W'(WIN_START + WIN_WIDTH);
   localparam logic [X_W-1:0]      ROW_PULSE_X = X_W'(H_ACTIVE - 1 - ROW_LEAD);
   localparam logic [LIN_W-1:0]    SCREEN_IDX  = LIN_W'(H_ACTIVE * V_ACTIVE - 1 - SCREEN_LEAD);
   localparam logic [ADDR_W-1:0]   ADDR_LAST   = ADDR_W'(WIN_WIDTH - 1);
   localparam logic [OUT_BITS-1:0] PAD_ONES    = OUT_BITS'((1 << PAD) - 1);

   // Line-buffer pixels are zero-padded; fixed colours replicate the channel LSB
   // into the pad bits so full-scale white stays full-scale on the wider bus.
   function automatic logic [OUT_BITS-1:0] widen_ch(input logic [COLOR_BITS-1:0] v,
                                                    input logic lsb_fill);
      widen_ch = (OUT_BITS'(v) << PAD) | ((lsb_fill && v[0]) ? PAD_ONES : '0);
   endfunction

   function automatic logic [3*OUT_BITS-1:0] widen(input logic [3*COLOR_BITS-1:0] c,
                                                   input logic lsb_fill);
      widen = {widen_ch(c[3*COLOR_BITS-1:2*COLOR_BITS], lsb_fill),
               widen_ch(c[2*COLOR_BITS-1:COLOR_BITS],   lsb_fill),
               widen_ch(c[COLOR_BITS-1:0],              lsb_fill)};
   endfunction

   localparam logic [3*OUT_BITS-1:0] BORDER_OUT = widen(BORDER_RGB, 1'b1);
   localparam logic [3*OUT_BITS-1:0] BG_OUT     = widen(BG_RGB, 1'b1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state, state_d;
   logic [X_W-1:0]        x, x_d, nx;
   logic [Y_W-1:0]        y, y_d, ny;
   logic [ADDR_W-1:0]     address_d;
   logic [3*OUT_BITS-1:0] src_data_d;
   logic                  src_valid_d, next_row_d, next_screen_d;
   logic                  load, transfer;
   logic [LIN_W-1:0]      lin_idx;

   assign transfer = src_valid & src_ready;
   assign lin_idx  = LIN_W'(y) * LIN_W'(H_ACTIVE) + LIN_W'(x);
   assign src_sop  = src_valid & (x == '0) & (y == '0);
   assign src_eop  = src_valid & (x == X_LAST) & (y == Y_LAST);

   always_comb begin
      state_d       = state;
      x_d           = x;
      y_d           = y;
      address_d     = address;
      src_data_d    = src_data;
      src_valid_d   = src_valid;
      nx            = '0;
      ny            = '0;
      load          = 1'b0;
      next_row_d    = transfer & (x == ROW_PULSE_X);
      next_screen_d = transfer & (lin_idx == SCREEN_IDX);

      case (state)
         IDLE: begin
            src_valid_d = 1'b0;
            if (start) begin
               load    = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (!src_valid || src_ready) begin
               if (x == X_LAST) begin
                  if (y == Y_LAST) begin
                     if (start) begin
                        load = 1'b1;
                     end else begin
                        state_d     = IDLE;
                        src_valid_d = 1'b0;
                        x_d         = '0;
                        y_d         = '0;
                        address_d   = '0;
                     end
                  end else begin
                     ny   = y + 1'b1;
                     load = 1'b1;
                  end
               end else begin
                  nx   = x + 1'b1;
                  ny   = y;
                  load = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The register always holds the pixel at (x,y); the colour is chosen for
      // the incoming column and the line-buffer word is taken in this same cycle.
      if (load) begin
         x_d         = nx;
         y_d         = ny;
         src_valid_d = 1'b1;
         if (nx >= WIN_FIRST && nx <= WIN_LAST) begin
            src_data_d = widen(data, 1'b0);
            if (address != ADDR_LAST) begin
               address_d = address + 1'b1;
            end
         end else begin
            src_data_d = (nx == BORDER_L || nx == BORDER_R) ? BORDER_OUT : BG_OUT;
            if (nx == '0) begin
               address_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clock_vga or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         address     <= '0;
         src_data    <= '0;
         src_valid   <= 1'b0;
         next_row    <= 1'b0;
         next_screen <= 1'b0;
      end else begin
         state       <= state_d;
         x           <= x_d;
         y           <= y_d;
         address     <= address_d;
         src_data    <= src_data_d;
         src_valid   <= src_valid_d;
         next_row    <= next_row_d;
         next_screen <= next_screen_d;
      end
   end

endmodule
